// File: rtl/msrv32_instr_packer.sv
// Packs an immediate plus register/function fields into an RV32I instruction word and streams it to instruction memory.
// Define MSRV32_PACK_CHECK_EN to drop requests whose immediate cannot be encoded and flag them on range_err_out.
module msrv32_instr_packer #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  start_in,
    input  logic [ADDR_WIDTH-1:0] start_addr_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    input  logic [2:0]            imm_type_in,
    input  logic [31:0]           imm_in,
    input  logic [6:0]            opcode_in,
    input  logic [4:0]            rd_in,
    input  logic [4:0]            rs1_in,
    input  logic [4:0]            rs2_in,
    input  logic [2:0]            funct3_in,
    input  logic [6:0]            funct7_in,
    output logic                  wr_en_out,
    output logic [ADDR_WIDTH-1:0] wr_addr_out,
    output logic [31:0]           wr_data_out,
    input  logic                  wr_ready_in,
    output logic [ADDR_WIDTH:0]   count_out,
    output logic                  range_err_out
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [2:0] TYPE_R   = 3'b000;
    localparam logic [2:0] TYPE_S   = 3'b010;
    localparam logic [2:0] TYPE_B   = 3'b011;
    localparam logic [2:0] TYPE_U   = 3'b100;
    localparam logic [2:0] TYPE_J   = 3'b101;
    localparam logic [2:0] TYPE_CSR = 3'b110;

    logic [31:0]         packed_word;
    logic                imm_ok;
    logic                accept;
    logic                complete;
    logic                full;
    logic [ADDR_WIDTH+1:0] committed;

    always_comb begin
        packed_word = '0;
        case (imm_type_in)
            TYPE_R:   packed_word = {funct7_in, rs2_in, rs1_in, funct3_in, rd_in, opcode_in};
            TYPE_S:   packed_word = {imm_in[11:5], rs2_in, rs1_in, funct3_in, imm_in[4:0], opcode_in};
            TYPE_B:   packed_word = {imm_in[12], imm_in[10:5], rs2_in, rs1_in, funct3_in,
                                     imm_in[4:1], imm_in[11], opcode_in};
            TYPE_U:   packed_word = {imm_in[31:12], rd_in, opcode_in};
            TYPE_J:   packed_word = {imm_in[20], imm_in[10:1], imm_in[11], imm_in[19:12], rd_in, opcode_in};
            TYPE_CSR: packed_word = {funct7_in, rs2_in, imm_in[4:0], funct3_in, rd_in, opcode_in};
            default:  packed_word = {imm_in[11:0], rs1_in, funct3_in, rd_in, opcode_in};
        endcase
    end

`ifdef MSRV32_PACK_CHECK_EN
    always_comb begin
        imm_ok = 1'b1;
        case (imm_type_in)
            TYPE_R:   imm_ok = 1'b1;
            TYPE_B:   imm_ok = ((imm_in[31:12] == '0) || (imm_in[31:12] == '1)) && !imm_in[0];
            TYPE_U:   imm_ok = (imm_in[11:0] == '0);
            TYPE_J:   imm_ok = ((imm_in[31:20] == '0) || (imm_in[31:20] == '1)) && !imm_in[0];
            TYPE_CSR: imm_ok = (imm_in[31:5] == '0);
            default:  imm_ok = (imm_in[31:11] == '0) || (imm_in[31:11] == '1);
        endcase
    end
`else
    assign imm_ok = 1'b1;
`endif

    // Capacity counts the word still waiting in the output register, so no more than DEPTH words are ever issued.
    assign committed = {1'b0, count_out} + {{(ADDR_WIDTH+1){1'b0}}, wr_en_out};
    assign full      = (committed >= (ADDR_WIDTH+2)'(DEPTH));
    assign ready_out = !full && (!wr_en_out || wr_ready_in) && !start_in;
    assign accept    = valid_in && ready_out;
    assign complete  = wr_en_out && wr_ready_in;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_en_out     <= 1'b0;
            wr_addr_out   <= '0;
            wr_data_out   <= '0;
            count_out     <= '0;
            range_err_out <= 1'b0;
        end else if (start_in) begin
            wr_en_out     <= 1'b0;
            wr_addr_out   <= start_addr_in;
            count_out     <= '0;
            range_err_out <= 1'b0;
        end else begin
            if (complete) begin
                wr_addr_out <= wr_addr_out + ADDR_WIDTH'(1);
                count_out   <= count_out + (ADDR_WIDTH+1)'(1);
            end
            if (accept && imm_ok) begin
                wr_data_out <= packed_word;
                wr_en_out   <= 1'b1;
            end else if (complete) begin
                wr_en_out   <= 1'b0;
            end
            if (accept && !imm_ok) begin
                range_err_out <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_msrv32_instr_packer.sv
// Bench for msrv32_instr_packer: a 1024-word and a 4-word instance share one request stream and are checked against a transaction-level model.
module tb_msrv32_instr_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [9:0]  start_addr;
    logic        valid;
    logic [2:0]  imm_type;
    logic [31:0] imm;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        wr_ready;

    logic        b_ready, b_wr_en, b_err;
    logic [9:0]  b_wr_addr;
    logic [31:0] b_wr_data;
    logic [10:0] b_count;

    logic        s_ready, s_wr_en, s_err;
    logic [1:0]  s_wr_addr;
    logic [31:0] s_wr_data;
    logic [2:0]  s_count;

    int checks = 0;
    int errors = 0;

    // model state, index 0 = 1024-word instance, 1 = 4-word instance
    int          m_addr[2];
    int          m_count[2];
    bit          m_err[2];
    bit          m_pend[2];
    logic [31:0] m_data[2];

    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];

    always #5 clk = ~clk;

    msrv32_instr_packer #(.ADDR_WIDTH(10)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .start_addr_in(start_addr),
        .valid_in(valid), .ready_out(b_ready), .imm_type_in(imm_type), .imm_in(imm),
        .opcode_in(opcode), .rd_in(rd), .rs1_in(rs1), .rs2_in(rs2), .funct3_in(funct3),
        .funct7_in(funct7), .wr_en_out(b_wr_en), .wr_addr_out(b_wr_addr), .wr_data_out(b_wr_data),
        .wr_ready_in(wr_ready), .count_out(b_count), .range_err_out(b_err)
    );

    msrv32_instr_packer #(.ADDR_WIDTH(2)) dut_small (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .start_addr_in(start_addr[1:0]),
        .valid_in(valid), .ready_out(s_ready), .imm_type_in(imm_type), .imm_in(imm),
        .opcode_in(opcode), .rd_in(rd), .rs1_in(rs1), .rs2_in(rs2), .funct3_in(funct3),
        .funct7_in(funct7), .wr_en_out(s_wr_en), .wr_addr_out(s_wr_addr), .wr_data_out(s_wr_data),
        .wr_ready_in(wr_ready), .count_out(s_count), .range_err_out(s_err)
    );

    always @(posedge clk) begin
        if (rst_n && !start && b_wr_en && wr_ready) got_q.push_back(b_wr_data);
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_enc(input logic [2:0] t, input logic [31:0] v);
        case (t)
            3'd0: return {funct7, rs2, rs1, funct3, rd, opcode};
            3'd2: return {v[11:5], rs2, rs1, funct3, v[4:0], opcode};
            3'd3: return {v[12], v[10:5], rs2, rs1, funct3, v[4:1], v[11], opcode};
            3'd4: return {v[31:12], rd, opcode};
            3'd5: return {v[20], v[10:1], v[11], v[19:12], rd, opcode};
            3'd6: return {funct7, rs2, v[4:0], funct3, rd, opcode};
            default: return {v[11:0], rs1, funct3, rd, opcode};
        endcase
    endfunction

    function automatic bit model_legal(input logic [2:0] t, input logic [31:0] v);
`ifdef MSRV32_PACK_CHECK_EN
        longint sv = longint'($signed(v));
        case (t)
            3'd0: return 1'b1;
            3'd3: return (sv >= -4096) && (sv <= 4095) && (v % 2 == 0);
            3'd4: return (v % 4096) == 0;
            3'd5: return (sv >= -(64'sd1 << 20)) && (sv < (64'sd1 << 20)) && (v % 2 == 0);
            3'd6: return v < 32;
            default: return (sv >= -2048) && (sv <= 2047);
        endcase
`else
        return 1'b1;
`endif
    endfunction

    function automatic bit model_ready(input int k);
        int depth = (k == 0) ? 1024 : 4;
        return !start && (m_count[k] + int'(m_pend[k]) < depth) && (!m_pend[k] || wr_ready);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_addr[k] = 0; m_count[k] = 0; m_err[k] = 0; m_pend[k] = 0; m_data[k] = '0;
        end
    endtask

    // advance the model by one clock using the currently driven inputs, then move to the next falling edge
    task automatic tick();
        bit rdy[2];
        for (int k = 0; k < 2; k++) rdy[k] = model_ready(k);
        for (int k = 0; k < 2; k++) begin
            int depth = (k == 0) ? 1024 : 4;
            if (start) begin
                m_addr[k] = int'(start_addr) % depth;
                m_count[k] = 0; m_err[k] = 0; m_pend[k] = 0;
            end else begin
                if (m_pend[k] && wr_ready) begin
                    if (k == 0) exp_q.push_back(m_data[0]);
                    m_addr[k] = (m_addr[k] + 1) % depth;
                    m_count[k]++;
                    m_pend[k] = 0;
                end
                if (valid && rdy[k]) begin
                    if (model_legal(imm_type, imm)) begin
                        m_pend[k] = 1; m_data[k] = model_enc(imm_type, imm);
                    end else begin
                        m_err[k] = 1;
                    end
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- drivers ----------------
    task automatic drive_req(input logic [2:0] t, input logic [31:0] v, input logic [6:0] op,
                             input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                             input logic [2:0] f3, input logic [6:0] f7);
        valid = 1'b1; imm_type = t; imm = v; opcode = op;
        rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7;
    endtask

    task automatic drive_random_req();
        logic [31:0] v;
        case ($urandom_range(0, 3))
            0: v = $urandom;
            1: v = 32'($signed($urandom_range(0, 10000)) - 5000);
            2: v = $urandom & 32'hFFFF_F000;
            default: v = 32'($urandom_range(0, 40));
        endcase
        drive_req(3'($urandom_range(0, 7)), v, 7'($urandom), 5'($urandom), 5'($urandom),
                  5'($urandom), 3'($urandom), 7'($urandom));
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1;
        checks++;
        if ({b_wr_en, b_wr_addr, b_wr_data, b_count, b_err} !== '0) begin
            errors++;
            $display("FAIL reset_big en=%0b addr=%0h data=%0h count=%0d err=%0b, required all 0",
                     b_wr_en, b_wr_addr, b_wr_data, b_count, b_err);
        end
        checks++;
        if ({s_wr_en, s_wr_addr, s_wr_data, s_count, s_err} !== '0) begin
            errors++;
            $display("FAIL reset_small en=%0b addr=%0h data=%0h count=%0d err=%0b, required all 0",
                     s_wr_en, s_wr_addr, s_wr_data, s_count, s_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_i_type();
        start = 1'b1; start_addr = 10'h010; valid = 1'b0; wr_ready = 1'b1;
        #1;
        checks++;
        if (b_ready !== 1'b0) begin errors++; $display("FAIL ready_during_start got=%0b want=0", b_ready); end
        tick();
        start = 1'b0;
        drive_req(3'd1, 32'hFFFF_FFFF, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0);
        #1;
        checks++;
        if (b_ready !== 1'b1) begin errors++; $display("FAIL ready_after_start got=%0b want=1", b_ready); end
        tick();
        valid = 1'b0;
        checks++;
        if (b_wr_en !== 1'b1 || b_wr_addr !== 10'h010 || b_wr_data !== 32'hFFF0_0093) begin
            errors++;
            $display("FAIL i_type_write en=%0b addr=%0h data=%0h want en=1 addr=010 data=fff00093",
                     b_wr_en, b_wr_addr, b_wr_data);
        end
        tick();
        checks++;
        if (b_wr_en !== 1'b0 || b_count !== 11'd1 || b_wr_addr !== 10'h011) begin
            errors++;
            $display("FAIL i_type_done en=%0b count=%0d addr=%0h want en=0 count=1 addr=011",
                     b_wr_en, b_count, b_wr_addr);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] words[3];
        words[0] = 32'h0000_0463; words[1] = 32'h0010_00EF; words[2] = 32'h1234_52B7;
        wr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: drive_req(3'd3, 32'd8, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0);
                1: drive_req(3'd5, 32'h800, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0);
                2: drive_req(3'd4, 32'h1234_5000, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0);
                default: valid = 1'b0;
            endcase
            if (i > 0) begin
                checks++;
                if (b_wr_en !== 1'b1 || b_wr_addr !== 10'(32'h010 + i) || b_wr_data !== words[i-1]) begin
                    errors++;
                    $display("FAIL b2b_word%0d en=%0b addr=%0h data=%0h want en=1 addr=%0h data=%0h",
                             i - 1, b_wr_en, b_wr_addr, b_wr_data, 32'h010 + i, words[i-1]);
                end
            end
            tick();
        end
        checks++;
        if (b_wr_en !== 1'b0 || b_count !== 11'd4 || b_wr_addr !== 10'h014) begin
            errors++;
            $display("FAIL b2b_done en=%0b count=%0d addr=%0h want en=0 count=4 addr=014",
                     b_wr_en, b_count, b_wr_addr);
        end
    endtask

    task automatic test_backpressure();
        logic [9:0]  hold_addr;
        logic [31:0] hold_data;
        int          c0;
        c0 = m_count[0];
        wr_ready = 1'b1;
        drive_req(3'd0, 32'h0, 7'h33, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom));
        hold_data = model_enc(3'd0, 32'h0);
        hold_addr = 10'(m_addr[0]);
        tick();
        valid = 1'b0; wr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (b_ready !== 1'b0 || b_wr_en !== 1'b1 || b_wr_addr !== hold_addr || b_wr_data !== hold_data) begin
                errors++;
                $display("FAIL hold_cycle%0d ready=%0b en=%0b addr=%0h data=%0h want ready=0 en=1 addr=%0h data=%0h",
                         i, b_ready, b_wr_en, b_wr_addr, b_wr_data, hold_addr, hold_data);
            end
            tick();
        end
        wr_ready = 1'b1;
        #1;
        checks++;
        if (b_ready !== 1'b1) begin errors++; $display("FAIL release_ready got=%0b want=1", b_ready); end
        tick();
        checks++;
        if (b_wr_en !== 1'b0 || int'(b_count) !== c0 + 1 || b_wr_addr !== hold_addr + 10'd1) begin
            errors++;
            $display("FAIL release_write en=%0b count=%0d addr=%0h want en=0 count=%0d addr=%0h",
                     b_wr_en, b_count, b_wr_addr, c0 + 1, hold_addr + 10'd1);
        end
    endtask

    task automatic test_range();
        int c0;
        logic [2:0]  types[2];
        logic [31:0] vals[2];
        types[0] = 3'd1; vals[0] = 32'd2048;
        types[1] = 3'd3; vals[1] = 32'd3;
        wr_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            c0 = int'(b_count);
            drive_req(types[i], vals[i], 7'h13, 5'd3, 5'd4, 5'd5, 3'd0, 7'd0);
            tick();
            valid = 1'b0;
`ifdef MSRV32_PACK_CHECK_EN
            checks++;
            if (b_wr_en !== 1'b0 || b_err !== 1'b1 || int'(b_count) !== c0) begin
                errors++;
                $display("FAIL range_drop%0d en=%0b err=%0b count=%0d want en=0 err=1 count=%0d",
                         i, b_wr_en, b_err, b_count, c0);
            end
`else
            checks++;
            if (b_wr_en !== 1'b1 || b_err !== 1'b0 || b_wr_data !== model_enc(types[i], vals[i])) begin
                errors++;
                $display("FAIL range_truncate%0d en=%0b err=%0b data=%0h want en=1 err=0 data=%0h",
                         i, b_wr_en, b_err, b_wr_data, model_enc(types[i], vals[i]));
            end
`endif
            tick();
        end
        start = 1'b1; start_addr = 10'h100;
        tick();
        start = 1'b0;
        checks++;
        if (b_err !== 1'b0 || b_count !== 11'd0 || b_wr_addr !== 10'h100) begin
            errors++;
            $display("FAIL start_clears err=%0b count=%0d addr=%0h want err=0 count=0 addr=100",
                     b_err, b_count, b_wr_addr);
        end
    endtask

    task automatic test_full();
        int exp_addr[4] = '{2, 3, 0, 1};
        int n = 0;
        start = 1'b1; start_addr = 10'd2; valid = 1'b0; wr_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive_req(3'd1, 32'($urandom_range(0, 2047)), 7'h13, 5'($urandom), 5'($urandom), 5'd0, 3'd0, 7'd0);
            if (s_wr_en) begin
                checks++;
                if (n >= 4 || int'(s_wr_addr) !== exp_addr[n]) begin
                    errors++;
                    $display("FAIL full_addr%0d got=%0d want=%0d", n, s_wr_addr, (n < 4) ? exp_addr[n] : -1);
                end
                n++;
            end
            tick();
        end
        #1;
        checks++;
        if (n != 4 || s_count !== 3'd4 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_state writes=%0d count=%0d ready=%0b want writes=4 count=4 ready=0",
                     n, s_count, s_ready);
        end
        valid = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        checks++;
        if (s_ready !== 1'b1 || s_count !== 3'd0) begin
            errors++;
            $display("FAIL full_restart ready=%0b count=%0d want ready=1 count=0", s_ready, s_count);
        end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int k = 0; k < 2; k++) begin
                bit          a_en  = (k == 0) ? b_wr_en : s_wr_en;
                int          a_adr = (k == 0) ? int'(b_wr_addr) : int'(s_wr_addr);
                int          a_cnt = (k == 0) ? int'(b_count) : int'(s_count);
                bit          a_err = (k == 0) ? b_err : s_err;
                logic [31:0] a_dat = (k == 0) ? b_wr_data : s_wr_data;
                checks++;
                if (a_en !== m_pend[k] || a_adr != m_addr[k] || a_cnt != m_count[k] || a_err !== m_err[k]
                    || (m_pend[k] && a_dat !== m_data[k])) begin
                    errors++;
                    $display("FAIL rand_state inst%0d cyc%0d en=%0b addr=%0d count=%0d err=%0b data=%0h want en=%0b addr=%0d count=%0d err=%0b data=%0h",
                             k, cyc, a_en, a_adr, a_cnt, a_err, a_dat,
                             m_pend[k], m_addr[k], m_count[k], m_err[k], m_data[k]);
                end
            end
            start      = ($urandom_range(0, 24) == 0);
            start_addr = 10'($urandom);
            wr_ready   = ($urandom_range(0, 9) < 7);
            drive_random_req();
            valid      = ($urandom_range(0, 9) < 7);
            #1;
            checks++;
            if (b_ready !== model_ready(0) || s_ready !== model_ready(1)) begin
                errors++;
                $display("FAIL rand_ready cyc%0d big=%0b small=%0b want big=%0b small=%0b",
                         cyc, b_ready, s_ready, model_ready(0), model_ready(1));
            end
            tick();
        end
        start = 1'b0; valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        wr_ready = 1'b0;
        drive_req(3'd1, 32'd5, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0);
        start = 1'b1; start_addr = 10'h055;
        tick();
        start = 1'b0;
        tick();
        valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({b_wr_en, b_wr_addr, b_wr_data, b_count, b_err, s_wr_en, s_wr_addr, s_wr_data, s_count, s_err} !== '0) begin
            errors++;
            $display("FAIL reset_mid big en=%0b addr=%0h count=%0d small en=%0b addr=%0h count=%0d, required all 0",
                     b_wr_en, b_wr_addr, b_count, s_wr_en, s_wr_addr, s_count);
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wr_ready = 1'b1;
        drive_req(3'd1, 32'd7, 7'h13, 5'd3, 5'd1, 5'd0, 3'd0, 7'd0);
        tick();
        valid = 1'b0;
        checks++;
        if (b_wr_en !== 1'b1 || b_wr_addr !== 10'd0 || s_wr_addr !== 2'd0 || b_wr_data !== 32'h0070_8193) begin
            errors++;
            $display("FAIL after_reset en=%0b addr=%0h small_addr=%0h data=%0h want en=1 addr=0 small_addr=0 data=00708193",
                     b_wr_en, b_wr_addr, s_wr_addr, b_wr_data);
        end
        tick();
    endtask

    task automatic test_scoreboard();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL sb_count got=%0d want=%0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [31:0] g = got_q.pop_front();
            logic [31:0] e = exp_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL sb_word got=%0h want=%0h", g, e);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; start_addr = '0; valid = 1'b0; wr_ready = 1'b0;
        imm_type = '0; imm = '0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0;
        model_reset();
        repeat (2) @(negedge clk);
        test_reset();
        test_i_type();
        test_back_to_back();
        test_backpressure();
        test_range();
        test_full();
        test_random();
        test_reset_mid();
        test_scoreboard();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
